// File: rtl/sdram_cmd_checker.sv
// SDRAM command-bus checker: decodes command pins, tracks per-bank open/idle state and
// inter-command gaps, and reports coded violations. Macro SDRAM_CHK_TRCAR_MEAS_EN adds AREF gap measurement.
module sdram_cmd_checker #(
   parameter int BANKS    = 4,
   parameter int BA_W     = 2,
   parameter int CNT_W    = 16,
   parameter int RF_SLACK = 64
) (
   input  logic             sdram_clk,
   input  logic             RESETN,
   input  logic             sdr_init_done,
   input  logic             sdr_cs_n,
   input  logic             sdr_ras_n,
   input  logic             sdr_cas_n,
   input  logic             sdr_we_n,
   input  logic [BA_W-1:0]  sdr_ba,
   input  logic             sdr_a10,
   input  logic [3:0]       SDR_trcd_d,
   input  logic [3:0]       SDR_tras_d,
   input  logic [3:0]       SDR_trp_d,
   input  logic [3:0]       SDR_trcar_d,
   input  logic [11:0]      SDR_rf_sh,
   output logic             viol_valid,
   output logic [2:0]       viol_code,
   output logic [BA_W-1:0]  viol_bank,
   output logic [CNT_W-1:0] viol_count,
   output logic             trcar_meas_vld,
   output logic [CNT_W-1:0] trcar_meas
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam int               RF_W    = ((CNT_W > 12) ? CNT_W : 12) + 1;
   localparam logic [RF_W-1:0]  RF_SLACK_W = RF_W'(RF_SLACK);

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_AREF, CMD_MRS
   } cmd_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   cmd_e             cmd;
   logic             is_cmd;
   logic [BANKS-1:0] open_q, open_d;
   logic [CNT_W-1:0] since_act_q [BANKS];
   logic [CNT_W-1:0] since_act_d [BANKS];
   logic [CNT_W-1:0] since_pre_q [BANKS];
   logic [CNT_W-1:0] since_pre_d [BANKS];
   logic [CNT_W-1:0] since_aref_q, since_aref_d;
   logic             rf_flag_q, rf_flag_d;
   logic             rf_due;
   logic [RF_W-1:0]  rf_limit;

   logic             viol_valid_q, viol_valid_d;
   logic [2:0]       viol_code_q, viol_code_d;
   logic [BA_W-1:0]  viol_bank_q, viol_bank_d;
   logic [CNT_W-1:0] viol_count_q, viol_count_d;

   logic             v_hit;
   logic [2:0]       v_code;
   logic [BA_W-1:0]  v_bank;
   logic             any_open;
   logic [BA_W-1:0]  low_open;
   logic             ras_hit;
   logic [BA_W-1:0]  ras_bank;

   always_comb begin
      cmd = CMD_NOP;
      if (!sdr_cs_n) begin
         case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_RD;
            3'b100:  cmd = CMD_WR;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_AREF;
            3'b000:  cmd = CMD_MRS;
            default: cmd = CMD_NOP;
         endcase
      end
      is_cmd = (cmd != CMD_NOP);
   end

   // Bank state and gap counters run whether or not checking is enabled.
   always_comb begin
      open_d       = open_q;
      since_aref_d = (cmd == CMD_AREF) ? CNT_ONE : sat_inc(since_aref_q);
      for (int b = 0; b < BANKS; b++) begin
         since_act_d[b] = sat_inc(since_act_q[b]);
         since_pre_d[b] = sat_inc(since_pre_q[b]);
         if (cmd == CMD_ACT && sdr_ba == BA_W'(b)) begin
            since_act_d[b] = CNT_ONE;
            open_d[b]      = 1'b1;
         end
         if (cmd == CMD_PRE && (sdr_a10 || sdr_ba == BA_W'(b))) begin
            since_pre_d[b] = CNT_ONE;
            open_d[b]      = 1'b0;
         end
      end
   end

   // The flag keeps refresh-late to one report per gap even if the counter parks on the limit.
   always_comb begin
      rf_limit  = RF_W'(SDR_rf_sh) + RF_SLACK_W;
      rf_due    = (RF_W'(since_aref_q) == rf_limit) && (cmd != CMD_AREF) && !rf_flag_q;
      rf_flag_d = (cmd == CMD_AREF) ? 1'b0 : (rf_flag_q | rf_due);
   end

   always_comb begin
      any_open = |open_q;
      low_open = '0;
      ras_hit  = 1'b0;
      ras_bank = '0;
      for (int b = BANKS - 1; b >= 0; b--) begin
         if (open_q[b]) low_open = BA_W'(b);
         if (cmd == CMD_PRE && (sdr_a10 || sdr_ba == BA_W'(b)) &&
             since_act_q[b] < CNT_W'(SDR_tras_d)) begin
            ras_hit  = 1'b1;
            ras_bank = BA_W'(b);
         end
      end
   end

   // Later assignments override earlier ones, so the lowest code wins.
   always_comb begin
      v_hit  = 1'b0;
      v_code = 3'd0;
      v_bank = '0;
      if (sdr_init_done) begin
         if (rf_due) begin
            v_hit = 1'b1; v_code = 3'd6; v_bank = '0;
         end
         if (is_cmd && since_aref_q < CNT_W'(SDR_trcar_d)) begin
            v_hit = 1'b1; v_code = 3'd5; v_bank = sdr_ba;
         end
         if (cmd == CMD_ACT && since_pre_q[sdr_ba] < CNT_W'(SDR_trp_d)) begin
            v_hit = 1'b1; v_code = 3'd4; v_bank = sdr_ba;
         end
         if (ras_hit) begin
            v_hit = 1'b1; v_code = 3'd3; v_bank = ras_bank;
         end
         if ((cmd == CMD_RD || cmd == CMD_WR) && since_act_q[sdr_ba] < CNT_W'(SDR_trcd_d)) begin
            v_hit = 1'b1; v_code = 3'd2; v_bank = sdr_ba;
         end
         if ((cmd == CMD_ACT && open_q[sdr_ba]) ||
             ((cmd == CMD_RD || cmd == CMD_WR) && !open_q[sdr_ba])) begin
            v_hit = 1'b1; v_code = 3'd1; v_bank = sdr_ba;
         end else if ((cmd == CMD_AREF || cmd == CMD_MRS) && any_open) begin
            v_hit = 1'b1; v_code = 3'd1; v_bank = low_open;
         end
      end
   end

   always_comb begin
      viol_valid_d = v_hit;
      viol_code_d  = v_hit ? v_code : viol_code_q;
      viol_bank_d  = v_hit ? v_bank : viol_bank_q;
      viol_count_d = (v_hit && viol_count_q != CNT_MAX) ? viol_count_q + CNT_ONE : viol_count_q;
   end

   always_ff @(posedge sdram_clk or negedge RESETN) begin
      if (!RESETN) begin
         open_q       <= '0;
         since_aref_q <= CNT_MAX;
         rf_flag_q    <= 1'b0;
         for (int b = 0; b < BANKS; b++) begin
            since_act_q[b] <= CNT_MAX;
            since_pre_q[b] <= CNT_MAX;
         end
         viol_valid_q <= 1'b0;
         viol_code_q  <= 3'd0;
         viol_bank_q  <= '0;
         viol_count_q <= '0;
      end else begin
         open_q       <= open_d;
         since_aref_q <= since_aref_d;
         rf_flag_q    <= rf_flag_d;
         for (int b = 0; b < BANKS; b++) begin
            since_act_q[b] <= since_act_d[b];
            since_pre_q[b] <= since_pre_d[b];
         end
         viol_valid_q <= viol_valid_d;
         viol_code_q  <= viol_code_d;
         viol_bank_q  <= viol_bank_d;
         viol_count_q <= viol_count_d;
      end
   end

   assign viol_valid = viol_valid_q;
   assign viol_code  = viol_code_q;
   assign viol_bank  = viol_bank_q;
   assign viol_count = viol_count_q;

`ifdef SDRAM_CHK_TRCAR_MEAS_EN
   logic             aref_pend_q, aref_pend_d;
   logic             meas_vld_q, meas_vld_d;
   logic [CNT_W-1:0] meas_q, meas_d;

   // The first real command after an AREF (including another AREF) captures the gap.
   always_comb begin
      meas_vld_d  = is_cmd && aref_pend_q;
      meas_d      = meas_vld_d ? since_aref_q : meas_q;
      aref_pend_d = (cmd == CMD_AREF) ? 1'b1 : (is_cmd ? 1'b0 : aref_pend_q);
   end

   always_ff @(posedge sdram_clk or negedge RESETN) begin
      if (!RESETN) begin
         aref_pend_q <= 1'b0;
         meas_vld_q  <= 1'b0;
         meas_q      <= '0;
      end else begin
         aref_pend_q <= aref_pend_d;
         meas_vld_q  <= meas_vld_d;
         meas_q      <= meas_d;
      end
   end

   assign trcar_meas_vld = meas_vld_q;
   assign trcar_meas     = meas_q;
`else
   assign trcar_meas_vld = 1'b0;
   assign trcar_meas     = '0;
`endif

endmodule

// File: tb/tb_sdram_cmd_checker.sv
// Bench for sdram_cmd_checker: directed protocol scenarios plus random command traffic, checked
// every cycle against a timestamp-based model of the command rules.
module tb_sdram_cmd_checker;
   localparam int BANKS = 4;
   localparam int BA_W  = 2;
   localparam int CNT_W = 8;
   localparam int SLACK = 64;
   localparam int MAXV  = (1 << CNT_W) - 1;

   localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4,
                  K_AREF = 5, K_MRS = 6, K_BST = 7, K_DES = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             init_done;
   logic             cs_n, ras_n, cas_n, we_n;
   logic [BA_W-1:0]  ba;
   logic             a10;
   logic [3:0]       trcd, tras, trp, trcar;
   logic [11:0]      rf_sh;
   logic             viol_valid;
   logic [2:0]       viol_code;
   logic [BA_W-1:0]  viol_bank;
   logic [CNT_W-1:0] viol_count;
   logic             trcar_meas_vld;
   logic [CNT_W-1:0] trcar_meas;

   sdram_cmd_checker #(
      .BANKS(BANKS), .BA_W(BA_W), .CNT_W(CNT_W), .RF_SLACK(SLACK)
   ) dut (
      .sdram_clk(clk), .RESETN(rst_n), .sdr_init_done(init_done),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_a10(a10),
      .SDR_trcd_d(trcd), .SDR_tras_d(tras), .SDR_trp_d(trp), .SDR_trcar_d(trcar),
      .SDR_rf_sh(rf_sh),
      .viol_valid(viol_valid), .viol_code(viol_code), .viol_bank(viol_bank),
      .viol_count(viol_count), .trcar_meas_vld(trcar_meas_vld), .trcar_meas(trcar_meas)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // expected word: {valid, code, bank, count, meas_vld, meas}
   localparam int W = 1 + 3 + BA_W + CNT_W + 1 + CNT_W;
   logic [W-1:0] exp_q[$];

   // Model state: edge timestamps of the last commands, -1 meaning "long ago".
   int               cyc;
   int               last_act[BANKS];
   int               last_pre[BANKS];
   int               last_aref;
   bit               open_b[BANKS];
   bit               m_pend;
   logic             e_vld, e_mvld;
   logic [2:0]       e_code;
   logic [BA_W-1:0]  e_bank;
   logic [CNT_W-1:0] e_cnt, e_meas;
   int               cur_kind, cur_ba;
   bit               cur_a10;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int gap(input int last);
      int d;
      if (last < 0) return MAXV;
      d = cyc - last;
      return (d > MAXV) ? MAXV : d;
   endfunction

   task automatic model_reset();
      cyc = 0;
      last_aref = -1;
      for (int b = 0; b < BANKS; b++) begin
         last_act[b] = -1;
         last_pre[b] = -1;
         open_b[b]   = 1'b0;
      end
      m_pend = 1'b0;
      e_vld = 1'b0; e_code = '0; e_bank = '0; e_cnt = '0; e_mvld = 1'b0; e_meas = '0;
   endtask

   // Outputs the DUT must show after the edge that samples the current pins.
   task automatic model_edge();
      int  best, bbank, lowb;
      bit  real_cmd, anyo;
      best = 99; bbank = 0;
      cyc++;
      real_cmd = (cur_kind >= K_ACT && cur_kind <= K_MRS);
      anyo = 1'b0; lowb = 0;
      for (int b = BANKS - 1; b >= 0; b--) if (open_b[b]) begin anyo = 1'b1; lowb = b; end
      if (init_done) begin
         if (cur_kind == K_ACT && open_b[cur_ba]) begin best = 1; bbank = cur_ba; end
         if ((cur_kind == K_RD || cur_kind == K_WR) && !open_b[cur_ba]) begin best = 1; bbank = cur_ba; end
         if ((cur_kind == K_AREF || cur_kind == K_MRS) && anyo) begin best = 1; bbank = lowb; end
         if (best > 2 && (cur_kind == K_RD || cur_kind == K_WR) && gap(last_act[cur_ba]) < int'(trcd)) begin
            best = 2; bbank = cur_ba;
         end
         if (best > 3 && cur_kind == K_PRE)
            for (int b = BANKS - 1; b >= 0; b--)
               if ((cur_a10 || b == cur_ba) && gap(last_act[b]) < int'(tras)) begin best = 3; bbank = b; end
         if (best > 4 && cur_kind == K_ACT && gap(last_pre[cur_ba]) < int'(trp)) begin best = 4; bbank = cur_ba; end
         if (best > 5 && real_cmd && gap(last_aref) < int'(trcar)) begin best = 5; bbank = cur_ba; end
         if (best > 6 && cur_kind != K_AREF && last_aref >= 0 && gap(last_aref) == int'(rf_sh) + SLACK) begin
            best = 6; bbank = 0;
         end
      end
      e_vld = (best < 99);
      if (e_vld) begin
         e_code = 3'(best);
         e_bank = BA_W'(bbank);
         if (e_cnt != '1) e_cnt = e_cnt + 1'b1;
      end
`ifdef SDRAM_CHK_TRCAR_MEAS_EN
      e_mvld = real_cmd && m_pend;
      if (e_mvld) e_meas = CNT_W'(gap(last_aref));
      if (cur_kind == K_AREF) m_pend = 1'b1;
      else if (real_cmd) m_pend = 1'b0;
`endif
      if (cur_kind == K_ACT) begin open_b[cur_ba] = 1'b1; last_act[cur_ba] = cyc; end
      if (cur_kind == K_PRE)
         for (int b = 0; b < BANKS; b++)
            if (cur_a10 || b == cur_ba) begin open_b[b] = 1'b0; last_pre[b] = cyc; end
      if (cur_kind == K_AREF) last_aref = cyc;
   endtask

   task automatic drive(input int kind, input int bank, input bit hi10);
      cur_kind = kind; cur_ba = bank; cur_a10 = hi10;
      cs_n = 1'b0;
      ba   = BA_W'(bank);
      a10  = hi10;
      case (kind)
         K_ACT:   {ras_n, cas_n, we_n} = 3'b011;
         K_RD:    {ras_n, cas_n, we_n} = 3'b101;
         K_WR:    {ras_n, cas_n, we_n} = 3'b100;
         K_PRE:   {ras_n, cas_n, we_n} = 3'b010;
         K_AREF:  {ras_n, cas_n, we_n} = 3'b001;
         K_MRS:   {ras_n, cas_n, we_n} = 3'b000;
         K_BST:   {ras_n, cas_n, we_n} = 3'b110;
         K_DES: begin cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'($urandom_range(0, 7)); end
         default: {ras_n, cas_n, we_n} = 3'b111;
      endcase
   endtask

   task automatic tick(input int kind, input int bank = 0, input bit hi10 = 1'b0);
      drive(kind, bank, hi10);
      model_edge();
      @(posedge clk);
      exp_q.push_back({e_vld, e_code, e_bank, e_cnt, e_mvld, e_meas});
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(K_NOP);
   endtask

   task automatic expect_lit(input string name, input logic v, input logic [2:0] c,
                             input logic [BA_W-1:0] b, input logic [CNT_W-1:0] n);
      chk({name, ".valid"}, 32'(viol_valid), 32'(v));
      chk({name, ".code"},  32'(viol_code),  32'(c));
      chk({name, ".bank"},  32'(viol_bank),  32'(b));
      chk({name, ".count"}, 32'(viol_count), 32'(n));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      drive(K_NOP, 0, 1'b0);
      #1;
      expect_lit("reset", 1'b0, 3'd0, '0, '0);
      chk("reset.meas_vld", 32'(trcar_meas_vld), 32'd0);
      chk("reset.meas",     32'(trcar_meas),     32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_timing(input int cd, input int ras, input int rp, input int car, input int rf);
      trcd = 4'(cd); tras = 4'(ras); trp = 4'(rp); trcar = 4'(car); rf_sh = 12'(rf);
   endtask

   always @(negedge clk) begin : compare
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("viol_valid",     32'(viol_valid),     32'(e[W-1]));
         chk("viol_code",      32'(viol_code),      32'(e[W-2 -: 3]));
         chk("viol_bank",      32'(viol_bank),      32'(e[W-5 -: BA_W]));
         chk("viol_count",     32'(viol_count),     32'(e[2*CNT_W : CNT_W+1]));
         chk("trcar_meas_vld", 32'(trcar_meas_vld), 32'(e[CNT_W]));
         chk("trcar_meas",     32'(trcar_meas),     32'(e[CNT_W-1:0]));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      init_done = 1'b1;
      set_timing(0, 0, 0, 0, 4000);
      do_reset();

      // tRCD: gap 2 against 3 is short, gap 3 is fine.
      set_timing(3, 0, 0, 0, 4000);
      tick(K_ACT, 1); tick(K_NOP); tick(K_RD, 1);
      expect_lit("trcd_short", 1'b1, 3'd2, 2'd1, 8'd1);
      tick(K_PRE, 1); tick(K_ACT, 1); idle(2); tick(K_RD, 1);
      expect_lit("trcd_ok", 1'b0, 3'd2, 2'd1, 8'd1);

      // tRAS then tRP on bank 0.
      do_reset();
      set_timing(0, 6, 0, 0, 4000);
      tick(K_ACT, 0); idle(3); tick(K_PRE, 0);
      expect_lit("tras", 1'b1, 3'd3, 2'd0, 8'd1);
      trp = 4'd2;
      tick(K_ACT, 0);
      expect_lit("trp", 1'b1, 3'd4, 2'd0, 8'd2);

      // Bank-state violations.
      do_reset();
      set_timing(0, 0, 0, 0, 4000);
      tick(K_ACT, 2); tick(K_ACT, 2);
      expect_lit("act_open", 1'b1, 3'd1, 2'd2, 8'd1);
      tick(K_RD, 3);
      expect_lit("rd_idle", 1'b1, 3'd1, 2'd3, 8'd2);
      tick(K_AREF);
      expect_lit("aref_open", 1'b1, 3'd1, 2'd2, 8'd3);

      // tRCAR and the optional measurement.
      do_reset();
      set_timing(0, 0, 0, 8, 4000);
      tick(K_AREF); idle(4); tick(K_ACT, 0);
      expect_lit("trcar", 1'b1, 3'd5, 2'd0, 8'd1);
`ifdef SDRAM_CHK_TRCAR_MEAS_EN
      chk("trcar_meas_lit.vld", 32'(trcar_meas_vld), 32'd1);
      chk("trcar_meas_lit.val", 32'(trcar_meas),     32'd5);
`else
      chk("trcar_meas_lit.vld", 32'(trcar_meas_vld), 32'd0);
      chk("trcar_meas_lit.val", 32'(trcar_meas),     32'd0);
`endif

      // Refresh late: exactly 164 clocks after the AREF, once.
      do_reset();
      set_timing(0, 0, 0, 0, 100);
      tick(K_AREF); idle(163);
      expect_lit("rf_before", 1'b0, 3'd0, 2'd0, 8'd0);
      tick(K_NOP);
      expect_lit("rf_late", 1'b1, 3'd6, 2'd0, 8'd1);
      idle(200);
      expect_lit("rf_once", 1'b0, 3'd6, 2'd0, 8'd1);

      // Checks disabled while init_done is low.
      do_reset();
      init_done = 1'b0;
      set_timing(3, 0, 0, 0, 4000);
      tick(K_ACT, 1); tick(K_NOP); tick(K_RD, 1);
      expect_lit("init_off", 1'b0, 3'd0, 2'd0, 8'd0);

      // Saturation: one violation per cycle well past 2^CNT_W.
      init_done = 1'b1;
      set_timing(0, 0, 0, 0, 4000);
      tick(K_ACT, 0);
      for (int i = 0; i < MAXV + 40; i++) tick(K_ACT, 0);
      expect_lit("saturate", 1'b1, 3'd1, 2'd0, 8'hff);

      // Reset mid-run clears outputs at once.
      tick(K_ACT, 0);
      #1;
      do_reset();

      // Random traffic.
      set_timing(2, 4, 2, 5, 60);
      for (int i = 0; i < 2500; i++) begin
         int r, kind;
         if (i % 100 == 0) begin
            init_done = ($urandom_range(0, 9) != 0);
            set_timing($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), 60);
         end
         r = $urandom_range(0, 99);
         if      (r < 20) kind = K_ACT;
         else if (r < 32) kind = K_RD;
         else if (r < 40) kind = K_WR;
         else if (r < 54) kind = K_PRE;
         else if (r < 57) kind = K_AREF;
         else if (r < 59) kind = K_MRS;
         else if (r < 62) kind = K_BST;
         else if (r < 70) kind = K_DES;
         else             kind = K_NOP;
         tick(kind, $urandom_range(0, BANKS - 1), 1'($urandom_range(0, 3) == 0));
      end
      idle(3);
      @(negedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
